// File: rtl/spi_seq_pkg.sv
// Shared opcodes, FSM state encoding and init-table entry layout for the SPI register sequencer.
package spi_seq_pkg;

   localparam logic [7:0] OP_WR = 8'hA1;
   localparam logic [7:0] OP_RD = 8'hA2;

   typedef enum logic [2:0] {
      ST_INIT_SEND = 3'd0,
      ST_INIT_WAIT = 3'd1,
      ST_INIT_DLY  = 3'd2,
      ST_IDLE      = 3'd3,
      ST_CMD_SEND  = 3'd4,
      ST_CMD_WAIT  = 3'd5,
      ST_RSP       = 3'd6
   } seq_state_e;

   // Fields are sized for the widest configuration; users slice what they need.
   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] dly;
   } init_entry_t;

   function automatic int unsigned read_flag_pos(input int unsigned addr_bytes);
      return 8 * addr_bytes - 1;
   endfunction

endpackage

// File: rtl/spi_init_rom.sv
// Power-up register table: combinational entry lookup by index.
// Define SPI_SEQ_FAST_SIM_EN to clamp every nonzero delay to at most 20 cycles.
module spi_init_rom
   import spi_seq_pkg::*;
#(
   parameter int INIT_DEPTH = 10,
   parameter int ADDR_BYTES = 2,
   parameter int DATA_BYTES = 2,
   parameter int DLY_W      = 16,
   parameter int EW         = $clog2(INIT_DEPTH + 1)
) (
   input  logic [EW-1:0]           idx_i,
   output logic [8*ADDR_BYTES-1:0] addr_o,
   output logic [8*DATA_BYTES-1:0] data_o,
   output logic [DLY_W-1:0]        dly_o
);

   init_entry_t ent_s;
   logic        unused_s;

   // Board table; entries at or beyond INIT_DEPTH are never addressed.
   always_comb begin
      ent_s = '0;
      case (32'(idx_i))
         32'd0:   ent_s = '{addr: 32'h0030, data: 32'h0001, dly: 32'd0};
         32'd1:   ent_s = '{addr: 32'h00F3, data: 32'h0000, dly: 32'd20};
         32'd2:   ent_s = '{addr: 32'h00F9, data: 32'hC007, dly: 32'd0};
         32'd3:   ent_s = '{addr: 32'h0031, data: 32'h0002, dly: 32'd20000};
         32'd4:   ent_s = '{addr: 32'h0040, data: 32'h00FF, dly: 32'd0};
         32'd5:   ent_s = '{addr: 32'h0041, data: 32'h0010, dly: 32'd0};
         32'd6:   ent_s = '{addr: 32'h0050, data: 32'h8000, dly: 32'd100};
         32'd7:   ent_s = '{addr: 32'h0051, data: 32'h0001, dly: 32'd0};
         32'd8:   ent_s = '{addr: 32'h0060, data: 32'h0003, dly: 32'd0};
         32'd9:   ent_s = '{addr: 32'h0061, data: 32'h0000, dly: 32'd0};
         default: ent_s = '0;
      endcase
   end

   assign addr_o = ent_s.addr[8*ADDR_BYTES-1:0];
   assign data_o = ent_s.data[8*DATA_BYTES-1:0];
`ifdef SPI_SEQ_FAST_SIM_EN
   assign dly_o  = (ent_s.dly > 32'd20) ? DLY_W'(32'd20) : DLY_W'(ent_s.dly);
`else
   assign dly_o  = DLY_W'(ent_s.dly);
`endif
   assign unused_s = ^{ent_s.addr, ent_s.data, ent_s.dly};

endmodule

// File: rtl/spi_reg_sequencer.sv
// SPI register sequencer: replays the init table, then serves host write/read commands.
// Init delays depend on SPI_SEQ_FAST_SIM_EN inside spi_init_rom.
module spi_reg_sequencer
   import spi_seq_pkg::*;
#(
   parameter int ADDR_BYTES = 2,
   parameter int DATA_BYTES = 2,
   parameter int INIT_DEPTH = 10,
   parameter int DLY_W      = 16
) (
   input  logic                    clk40M,
   input  logic                    rst,
   input  logic                    cmdValid,
   output logic                    cmdReady,
   input  logic [7:0]              cmdOp,
   input  logic [8*ADDR_BYTES-1:0] cmdAddr,
   input  logic [8*DATA_BYTES-1:0] cmdData,
   output logic                    rspValid,
   output logic                    rspErr,
   output logic [8*DATA_BYTES-1:0] rspData,
   output logic                    initDone,
   output logic [7:0]              txByte,
   output logic                    txDv,
   input  logic                    txReady,
   input  logic                    rxDv,
   input  logic [7:0]              rxByte
);

   localparam int AW = 8 * ADDR_BYTES;
   localparam int DW = 8 * DATA_BYTES;
   localparam int NB = ADDR_BYTES + DATA_BYTES;
   localparam int FW = 8 * NB;
   localparam int BW = $clog2(NB + 1);
   localparam int EW = $clog2(INIT_DEPTH + 1);
   localparam logic [AW-1:0] RD_FLAG = AW'(64'd1 << read_flag_pos(ADDR_BYTES));

   seq_state_e     state_q, state_d;
   logic [EW-1:0]  ent_q, ent_d;
   logic [BW-1:0]  byte_q, byte_d, rxcnt_q, rxcnt_d;
   logic [DLY_W-1:0] dly_q, dly_d;
   logic [7:0]     op_q, op_d, tx_byte_q, tx_byte_d;
   logic [AW-1:0]  addr_q, addr_d, rom_addr_s;
   logic [DW-1:0]  data_q, data_d, rxbuf_q, rxbuf_d, rsp_data_q, rsp_data_d, rom_data_s;
   logic [DLY_W-1:0] rom_dly_s;
   logic           txrdy_q, tx_dv_q, tx_dv_d, rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
   logic           init_done_q, init_done_d, cmd_ready_q, cmd_ready_d;
   logic [FW-1:0]  frame_s;
   logic [7:0]     cur_byte_s;
   logic           rise_s, last_byte_s, rx_take_s, op_ok_s;

   spi_init_rom #(
      .INIT_DEPTH (INIT_DEPTH),
      .ADDR_BYTES (ADDR_BYTES),
      .DATA_BYTES (DATA_BYTES),
      .DLY_W      (DLY_W),
      .EW         (EW)
   ) u_rom (
      .idx_i  (ent_q),
      .addr_o (rom_addr_s),
      .data_o (rom_data_s),
      .dly_o  (rom_dly_s)
   );

   assign rise_s      = txReady && !txrdy_q;
   assign last_byte_s = (byte_q == BW'(NB - 1));
   assign rx_take_s   = rxDv && (op_q == OP_RD) &&
                        ((state_q == ST_CMD_SEND) || (state_q == ST_CMD_WAIT));
   assign op_ok_s     = (cmdOp == OP_WR) || (cmdOp == OP_RD);
   assign cur_byte_s  = 8'(frame_s >> {byte_q, 3'b000});

   // Wire frame: address LSB first, then data LSB first; reads carry the flag and zero data.
   always_comb begin
      frame_s = {data_q, addr_q};
      if (!init_done_q) begin
         frame_s = {rom_data_s, rom_addr_s};
      end else if (op_q == OP_RD) begin
         frame_s = {{DW{1'b0}}, addr_q | RD_FLAG};
      end else begin
         frame_s = {data_q, addr_q};
      end
   end

   // Next-state logic for the sequencer FSM, read capture and registered outputs.
   always_comb begin
      state_d     = state_q;
      ent_d       = ent_q;
      byte_d      = byte_q;
      dly_d       = dly_q;
      op_d        = op_q;
      addr_d      = addr_q;
      data_d      = data_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      init_done_d = init_done_q;
      tx_byte_d   = tx_byte_q;
      tx_dv_d     = 1'b0;
      rsp_valid_d = 1'b0;
      rxcnt_d     = rx_take_s ? rxcnt_q + BW'(1) : rxcnt_q;
      rxbuf_d     = rxbuf_q;
      for (int k = 0; k < DATA_BYTES; k++) begin
         rxbuf_d[8*k +: 8] = (rx_take_s && (rxcnt_q == BW'(ADDR_BYTES + k))) ?
                             rxByte : rxbuf_q[8*k +: 8];
      end
      case (state_q)
         ST_INIT_SEND, ST_CMD_SEND: begin
            if (txReady) begin
               tx_dv_d   = 1'b1;
               tx_byte_d = cur_byte_s;
               state_d   = (state_q == ST_INIT_SEND) ? ST_INIT_WAIT : ST_CMD_WAIT;
            end else begin
               state_d = state_q;
            end
         end
         ST_INIT_WAIT: begin
            if (rise_s && !last_byte_s) begin
               byte_d  = byte_q + BW'(1);
               state_d = ST_INIT_SEND;
            end else if (rise_s && (ent_q == EW'(INIT_DEPTH - 1))) begin
               byte_d      = '0;
               state_d     = ST_IDLE;
               init_done_d = 1'b1;
            end else if (rise_s) begin
               byte_d  = '0;
               ent_d   = ent_q + EW'(1);
               dly_d   = rom_dly_s;
               state_d = (rom_dly_s != '0) ? ST_INIT_DLY : ST_INIT_SEND;
            end else begin
               state_d = state_q;
            end
         end
         ST_INIT_DLY: begin
            if (dly_q <= DLY_W'(1)) begin
               state_d = ST_INIT_SEND;
            end else begin
               dly_d = dly_q - DLY_W'(1);
            end
         end
         ST_IDLE: begin
            if (cmdValid && cmd_ready_q) begin
               op_d    = cmdOp;
               addr_d  = cmdAddr;
               data_d  = cmdData;
               byte_d  = '0;
               rxcnt_d = '0;
               rxbuf_d = '0;
               if (op_ok_s) begin
                  state_d = ST_CMD_SEND;
               end else begin
                  state_d     = ST_RSP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_data_d  = '0;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CMD_WAIT: begin
            if (rise_s && last_byte_s) begin
               state_d     = ST_RSP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_data_d  = (op_q == OP_RD) ? rxbuf_d : '0;
            end else if (rise_s) begin
               byte_d  = byte_q + BW'(1);
               state_d = ST_CMD_SEND;
            end else begin
               state_d = state_q;
            end
         end
         ST_RSP:  state_d = ST_IDLE;
         default: state_d = ST_INIT_SEND;
      endcase
      cmd_ready_d = (state_d == ST_IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk40M) begin
      if (rst) begin
         state_q     <= ST_INIT_SEND;
         ent_q       <= '0;
         byte_q      <= '0;
         rxcnt_q     <= '0;
         dly_q       <= '0;
         op_q        <= 8'h00;
         addr_q      <= '0;
         data_q      <= '0;
         rxbuf_q     <= '0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         init_done_q <= 1'b0;
         cmd_ready_q <= 1'b0;
         tx_dv_q     <= 1'b0;
         tx_byte_q   <= 8'h00;
         txrdy_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         ent_q       <= ent_d;
         byte_q      <= byte_d;
         rxcnt_q     <= rxcnt_d;
         dly_q       <= dly_d;
         op_q        <= op_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         rxbuf_q     <= rxbuf_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         rsp_valid_q <= rsp_valid_d;
         init_done_q <= init_done_d;
         cmd_ready_q <= cmd_ready_d;
         tx_dv_q     <= tx_dv_d;
         tx_byte_q   <= tx_byte_d;
         txrdy_q     <= txReady;
      end
   end

   assign cmdReady = cmd_ready_q;
   assign rspValid = rsp_valid_q;
   assign rspErr   = rsp_err_q;
   assign rspData  = rsp_data_q;
   assign initDone = init_done_q;
   assign txDv     = tx_dv_q;
   assign txByte   = tx_byte_q;

endmodule
